// File: rtl/z80_exec_pkg.sv
// Shared types and constants for the Z80 post-load execute sequencer.
// Holds the FSM state encoding, the default SP value and the parameter defaults.
package z80_exec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    REQ,
    SET,
    RELEASE
  } execState_t;

  localparam logic [15:0] SP_DEFAULT = 16'h4200;

  localparam int SET_CYCLES_DEF     = 4;
  localparam int RELEASE_CYCLES_DEF = 2;
  localparam int BUSAK_TIMEOUT_DEF  = 1024;

  // Width needed to hold 0..maxCount, never less than one bit.
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/z80_exec_ce_pulse_counter.sv
// Saturating counter of cpu_ce pulses, cleared while the owning state is inactive.
// o_terminal is high on the cycle whose pulse completes the count, or once saturated.
module ce_pulse_counter
  import z80_exec_pkg::*;
#(
  parameter int MAX_COUNT = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_ce,
  output logic o_terminal
);

  localparam int W = cntWidth(MAX_COUNT);
  localparam logic [W:0] MAX_V = (W+1)'(MAX_COUNT);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  assign w_sum      = {1'b0, r_count} + {{W{1'b0}}, (i_enable & i_ce)};
  assign o_terminal = (w_sum >= MAX_V);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && i_ce && (r_count != MAX_V[W-1:0])) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/z80_exec_ctrl.sv
// Post-load jump sequencer: captures the transfer address during a download, then
// stalls the CPU via BUSRQ and pulses the register loader's set strobe before release.
module z80_exec_ctrl
  import z80_exec_pkg::*;
#(
  parameter int SET_CYCLES     = SET_CYCLES_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF,
  parameter int BUSAK_TIMEOUT  = BUSAK_TIMEOUT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_ce,
  input  logic        load_active,
  input  logic        xfer_valid,
  input  logic [15:0] xfer_addr,
  input  logic        autorun,
  input  logic        cpu_busak_n,
  output logic        cpu_busrq_n,
  output logic        dir_set,
  output logic [15:0] execute_addr,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int TW = cntWidth(BUSAK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSAK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_CAP  = TW'(BUSAK_TIMEOUT);

  execState_t    r_state;
  execState_t    w_nextState;
  logic          r_loadPrev;
  logic          r_addrOk;
  logic [15:0]   r_execAddr;
  logic          r_timeoutErr;
  logic          r_done;
  logic [TW-1:0] r_reqCnt;
  logic          w_loadFall;
  logic          w_loadRise;
  logic          w_setTerm;
  logic          w_relTerm;
  logic          w_enterLoading;
  logic          w_timeoutHit;
  logic          w_commit;
  logic          w_capture;

  assign w_loadFall = r_loadPrev & ~load_active;
  assign w_loadRise = load_active & ~r_loadPrev;
  assign w_capture  = (r_state == LOADING) && xfer_valid;

  ce_pulse_counter #(.MAX_COUNT(SET_CYCLES)) u_setCnt (
    .i_clk      (clk_sys),
    .i_reset_n  (reset_n),
    .i_clear    (r_state != SET),
    .i_enable   (r_state == SET),
    .i_ce       (cpu_ce),
    .o_terminal (w_setTerm)
  );

  ce_pulse_counter #(.MAX_COUNT(RELEASE_CYCLES)) u_relCnt (
    .i_clk      (clk_sys),
    .i_reset_n  (reset_n),
    .i_clear    (r_state != RELEASE),
    .i_enable   (r_state == RELEASE),
    .i_ce       (cpu_ce),
    .o_terminal (w_relTerm)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (load_active) w_nextState = LOADING;
      LOADING: begin
        // A strobe on the falling-edge cycle still counts for the autorun decision.
        if (w_loadFall) begin
          w_nextState = ((r_addrOk || xfer_valid) && autorun) ? REQ : IDLE;
        end
      end
      REQ: begin
        if (w_loadRise)             w_nextState = LOADING;
        else if (!cpu_busak_n)      w_nextState = SET;
        else if (r_reqCnt == TO_LAST) w_nextState = IDLE;
      end
      SET: begin
        if (w_loadRise)     w_nextState = LOADING;
        else if (w_setTerm) w_nextState = RELEASE;
      end
      RELEASE: begin
        if (w_loadRise)     w_nextState = LOADING;
        else if (w_relTerm) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_enterLoading = (w_nextState == LOADING) && (r_state != LOADING);
  assign w_timeoutHit   = (r_state == REQ) && !w_loadRise && cpu_busak_n && (r_reqCnt == TO_LAST);
  assign w_commit       = (r_state == RELEASE) && !w_loadRise && w_relTerm;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_loadPrev   <= 1'b0;
      r_addrOk     <= 1'b0;
      r_execAddr   <= 16'h0000;
      r_timeoutErr <= 1'b0;
      r_done       <= 1'b0;
      r_reqCnt     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_loadPrev <= load_active;
      r_done     <= w_commit;
      if (w_enterLoading) begin
        r_addrOk     <= 1'b0;
        r_timeoutErr <= 1'b0;
      end else begin
        if (w_capture)    r_addrOk     <= 1'b1;
        if (w_timeoutHit) r_timeoutErr <= 1'b1;
      end
      if (w_capture) r_execAddr <= xfer_addr;
      if (r_state != REQ)          r_reqCnt <= '0;
      else if (r_reqCnt != TO_CAP) r_reqCnt <= r_reqCnt + 1'b1;
    end
  end

  assign cpu_busrq_n  = !((r_state == REQ) || (r_state == SET) || (r_state == RELEASE));
  assign dir_set      = (r_state == SET);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign timeout_err  = r_timeoutErr;
  assign execute_addr = r_execAddr;

endmodule

// File: doc/z80_exec_ctrl.md
Name: z80_exec_ctrl

Overview:
Sequences the post-load "jump to program" operation for the Z80 register loader. Captures the transfer (execute) address reported by the CMD/snapshot loader during a download. When the download ends with autorun enabled, it stalls the CPU via bus request and drives the register loader's set strobe for a fixed number of CPU clock enables. It then releases the CPU, which resumes at the captured PC with SP preset. Sits between the ioctl download/CMD parser and the T80pa DIR interface.

Parameters:
SET_CYCLES, 4, number of cpu_ce pulses dir_set is held high (1..15)
RELEASE_CYCLES, 2, cpu_ce pulses between dir_set low and busrq release (0..15)
BUSAK_TIMEOUT, 1024, clk_sys cycles to wait for bus acknowledge before abort (≥2)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_ce  in  1  CPU clock-enable pulse, one clk_sys wide
load_active  in  1  high while a program download is in progress
xfer_valid  in  1  one-cycle strobe: xfer_addr holds a transfer address
xfer_addr  in  16  transfer address from the CMD parser
autorun  in  1  OSD option: jump after load
cpu_busak_n  in  1  Z80 bus acknowledge, active low
cpu_busrq_n  out  1  Z80 bus request, active low
dir_set  out  1  register-set strobe to the register loader
execute_addr  out  16  latched PC for the register loader
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the jump has been committed
timeout_err  out  1  sticky, set on bus-acknowledge timeout

Behaviour:
- Reset values: cpu_busrq_n=1, dir_set=0, execute_addr=16'h0000, busy=0, done=0, timeout_err=0. Internal addr_ok=0. FSM goes to IDLE.
- States: IDLE, LOADING, REQ, SET, RELEASE.
- IDLE:
  - load_active=1 -> LOADING.
  - Clear addr_ok on entry to LOADING. Clear timeout_err on entry to LOADING.
- LOADING:
  - xfer_valid=1 latches xfer_addr into execute_addr and sets addr_ok. The last strobe wins.
  - Address 0000h is legal.
  - On load_active falling (registered 1->0): if addr_ok && autorun -> REQ; else -> IDLE. execute_addr is kept in both cases.
- REQ:
  - cpu_busrq_n=0. Start a clk_sys counter.
  - cpu_busak_n sampled 0 -> SET.
  - If the counter reaches BUSAK_TIMEOUT: set timeout_err, cpu_busrq_n=1, -> IDLE. No dir_set is issued.
- SET:
  - cpu_busrq_n=0, dir_set=1 (registered, asserted the cycle after entry).
  - Count cpu_ce pulses. After the SET_CYCLES-th pulse, dir_set=0 next cycle -> RELEASE.
- RELEASE:
  - cpu_busrq_n=0. Count RELEASE_CYCLES cpu_ce pulses.
  - Then cpu_busrq_n=1, done=1 for one clk_sys, -> IDLE.
  - With RELEASE_CYCLES=0 the exit happens the cycle after SET exits.
- cpu_ce held low stalls SET/RELEASE indefinitely. No timeout applies in these states.
- load_active rising in REQ, SET or RELEASE aborts the sequence:
  - Next cycle dir_set=0, cpu_busrq_n=1, -> LOADING (addr_ok cleared).
  - done is not pulsed.
- xfer_valid outside LOADING is ignored.
- xfer_valid coincident with the load_active falling edge is captured before the autorun decision.
- autorun is sampled only at the load_active falling edge.
- Counters are sized to their parameter, saturate at terminal count and are cleared on state entry.
- dir_set is never high unless cpu_busrq_n=0 and cpu_busak_n was seen 0 in this sequence.
- Asynchronous reset mid-sequence returns all outputs to reset values immediately.

Decomposition:
- Shared package z80_exec_pkg: state enum typedef, SP_DEFAULT 16'h4200 constant, default parameter constants.
- One natural sub-module: ce_pulse_counter (load, count on cpu_ce, terminal flag). It is instantiated for SET and RELEASE, or shared with a reload between them.
- The FSM stays in z80_exec_ctrl.

Test Plan:
1. Autorun jump:
   - Stimulus: load_active 1, xfer_valid with 5200h, load_active 0, autorun=1, busak 3 cycles after busrq.
   - Response: execute_addr=5200h, dir_set high for exactly 4 cpu_ce, busrq released 2 cpu_ce later, one done pulse.
2. Multiple transfer addresses:
   - Stimulus: two strobes, 5200h then 6000h.
   - Response: execute_addr=6000h at jump.
3. No jump:
   - Stimulus: load with no xfer_valid, or with autorun=0.
   - Response: returns to IDLE, busrq never asserted, dir_set never high, done=0.
4. Bus acknowledge timeout:
   - Stimulus: cpu_busak_n stuck at 1.
   - Response: after 1024 cycles timeout_err=1, busrq_n=1, dir_set never high. The next load clears timeout_err.
5. Abort by new load:
   - Stimulus: load_active rises during SET (cpu_ce every 4 clocks).
   - Response: dir_set and busrq drop next cycle, state LOADING, no done pulse. A subsequent normal finish jumps to the new address.
6. Async reset mid-sequence:
   - Stimulus: reset_n pulsed low during RELEASE.
   - Response: all outputs return to reset values without waiting for clk_sys.
   - Stimulus: cpu_ce held low in SET.
   - Response: dir_set stays high, no timeout.
